// File: rtl/issue_scheduler_pkg.sv
// Shared issue-stage types: decoded instruction, scoreboard encoding and helpers.
package issue_scheduler_pkg;

  localparam int THREAD_NUMB     = 8;
  localparam int REGISTER_NUMBER = 64;
  localparam int MASK_REG        = 60;

  localparam int THREAD_IDX_W = $clog2(THREAD_NUMB);
  localparam int REG_ADDR_W   = $clog2(REGISTER_NUMBER);
  localparam int SB_W         = 2 * REGISTER_NUMBER;

  typedef logic [THREAD_IDX_W-1:0] thread_id_t;
  typedef logic [REG_ADDR_W-1:0]   reg_addr_t;
  typedef logic [SB_W-1:0]         scoreboard_t;

  typedef struct packed {
    logic [7:0] op_code;
    reg_addr_t  source0;
    reg_addr_t  source1;
    reg_addr_t  destination;
    logic       is_source0_vectorial;
    logic       is_source1_vectorial;
    logic       is_destination_vectorial;
    logic       is_source1_immediate;
    logic       has_source0;
    logic       has_source1;
    logic       has_destination;
    logic       mask_enable;
  } instruction_decoded_t;

  // Scalar r lives at bit r, vector r at bit REGISTER_NUMBER+r.
  function automatic scoreboard_t reg_to_scoreboard_bit(input reg_addr_t r, input logic is_vec);
    int idx;
    idx = is_vec ? (REGISTER_NUMBER + int'(r)) : int'(r);
    return scoreboard_t'(1) << idx;
  endfunction

endpackage

// File: rtl/issue_scheduler_rr_arbiter.sv
// Round-robin arbiter: searches upward from an internal pointer, one-hot grant.
module rr_arbiter #(
  parameter int N = 8
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic [N-1:0] i_request,
  input  logic         i_update_en,
  output logic [N-1:0] o_grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_next;
  logic          w_found;
  int            w_idx;

  always_comb begin
    o_grant    = '0;
    w_ptr_next = r_ptr;
    w_found    = 1'b0;
    w_idx      = 0;
    for (int i = 0; i < N; i++) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= N) w_idx = w_idx - N;
      if (!w_found && i_request[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
        w_ptr_next     = (w_idx == N - 1) ? '0 : PW'(w_idx + 1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n)                 r_ptr <= '0;
    else if (i_update_en && w_found) r_ptr <= w_ptr_next;
  end

endmodule

// File: rtl/issue_scheduler.sv
// Issue stage: per-thread RAW/WAW scoreboard check, round-robin pick, registered issue to operand fetch.
module issue_scheduler
  import issue_scheduler_pkg::*;
(
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    enable,
  input  logic [THREAD_NUMB-1:0]                  ib_valid,
  input  instruction_decoded_t [THREAD_NUMB-1:0]  ib_inst,
  output logic [THREAD_NUMB-1:0]                  ib_dequeue,
  input  logic [THREAD_NUMB-1:0]                  thread_enable,
  input  logic [THREAD_NUMB-1:0]                  rollback_valid,
  input  scoreboard_t                             rollback_clear_bitmap,
  input  logic                                    wb_valid,
  input  thread_id_t                              wb_thread_id,
  input  reg_addr_t                               wb_register,
  input  logic                                    wb_is_scalar,
  output logic                                    issue_valid,
  output thread_id_t                              issue_thread_id,
  output instruction_decoded_t                    issue_inst_scheduled,
  output scoreboard_t                             issue_destination_bitmap
);

  scoreboard_t [THREAD_NUMB-1:0] r_sb;
  scoreboard_t [THREAD_NUMB-1:0] w_sb_next;
  scoreboard_t [THREAD_NUMB-1:0] w_req;
  scoreboard_t [THREAD_NUMB-1:0] w_dst_bit;
  scoreboard_t [THREAD_NUMB-1:0] w_clr;
  scoreboard_t                   w_wb_bit;
  logic [THREAD_NUMB-1:0]        w_hazard;
  logic [THREAD_NUMB-1:0]        w_eligible;
  logic [THREAD_NUMB-1:0]        w_grant;
  thread_id_t                    w_gid;

  logic                 r_issue_valid;
  thread_id_t           r_issue_tid;
  instruction_decoded_t r_issue_inst;
  scoreboard_t          r_issue_dst;

  // Hazard check looks only at the registered scoreboard; releases take effect a cycle later.
  always_comb begin
    w_wb_bit  = reg_to_scoreboard_bit(wb_register, ~wb_is_scalar);
    w_req     = '0;
    w_dst_bit = '0;
    w_clr     = '0;
    w_hazard  = '0;
    for (int t = 0; t < THREAD_NUMB; t++) begin
      if (ib_inst[t].has_destination)
        w_dst_bit[t] = reg_to_scoreboard_bit(ib_inst[t].destination,
                                             ib_inst[t].is_destination_vectorial);
      w_req[t] = w_dst_bit[t];
      if (ib_inst[t].has_source0)
        w_req[t] = w_req[t] | reg_to_scoreboard_bit(ib_inst[t].source0,
                                                    ib_inst[t].is_source0_vectorial);
      if (ib_inst[t].has_source1 && !ib_inst[t].is_source1_immediate)
        w_req[t] = w_req[t] | reg_to_scoreboard_bit(ib_inst[t].source1,
                                                    ib_inst[t].is_source1_vectorial);
      if (ib_inst[t].mask_enable)
        w_req[t][MASK_REG] = 1'b1;
      w_hazard[t] = |(w_req[t] & r_sb[t]);
      if (rollback_valid[t])
        w_clr[t] = rollback_clear_bitmap;
      if (wb_valid && (wb_thread_id == thread_id_t'(t)))
        w_clr[t] = w_clr[t] | w_wb_bit;
    end
  end

  assign w_eligible = ib_valid & thread_enable & ~rollback_valid & ~w_hazard
                    & {THREAD_NUMB{enable & reset}};

  rr_arbiter #(.N(THREAD_NUMB)) u_arb (
    .i_clk       (clk),
    .i_reset_n   (reset),
    .i_request   (w_eligible),
    .i_update_en (enable),
    .o_grant     (w_grant)
  );

  assign ib_dequeue = w_grant;

  // Set is applied after clear so a same-bit collision keeps the bit busy.
  always_comb begin
    w_sb_next = '0;
    w_gid     = '0;
    for (int t = 0; t < THREAD_NUMB; t++) begin
      w_sb_next[t] = (r_sb[t] & ~w_clr[t]) | (w_grant[t] ? w_dst_bit[t] : '0);
      if (w_grant[t]) w_gid = thread_id_t'(t);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sb          <= '0;
      r_issue_valid <= 1'b0;
      r_issue_tid   <= '0;
      r_issue_inst  <= '0;
      r_issue_dst   <= '0;
    end else begin
      r_sb <= w_sb_next;
      if (enable) begin
        r_issue_valid <= |w_grant;
        if (|w_grant) begin
          r_issue_tid  <= w_gid;
          r_issue_inst <= ib_inst[w_gid];
          r_issue_dst  <= w_dst_bit[w_gid];
        end
      end
    end
  end

  assign issue_valid              = r_issue_valid;
  assign issue_thread_id          = r_issue_tid;
  assign issue_inst_scheduled     = r_issue_inst;
  assign issue_destination_bitmap = r_issue_dst;

endmodule

// File: tb/tb_issue_scheduler.sv
// Scoreboard bench for issue_scheduler: directed hazard/arbitration vectors, monitor checks every issue.
module tb_issue_scheduler;
  import issue_scheduler_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                                   reset, enable;
  logic [THREAD_NUMB-1:0]                 ib_valid, ib_dequeue, thread_enable, rollback_valid;
  instruction_decoded_t [THREAD_NUMB-1:0] ib_inst;
  scoreboard_t                            rollback_clear_bitmap;
  logic                                   wb_valid, wb_is_scalar;
  thread_id_t                             wb_thread_id;
  reg_addr_t                              wb_register;
  logic                                   issue_valid;
  thread_id_t                             issue_thread_id;
  instruction_decoded_t                   issue_inst_scheduled;
  scoreboard_t                            issue_destination_bitmap;

  issue_scheduler dut (
    .clk(clk), .reset(reset), .enable(enable),
    .ib_valid(ib_valid), .ib_inst(ib_inst), .ib_dequeue(ib_dequeue),
    .thread_enable(thread_enable), .rollback_valid(rollback_valid),
    .rollback_clear_bitmap(rollback_clear_bitmap),
    .wb_valid(wb_valid), .wb_thread_id(wb_thread_id), .wb_register(wb_register),
    .wb_is_scalar(wb_is_scalar),
    .issue_valid(issue_valid), .issue_thread_id(issue_thread_id),
    .issue_inst_scheduled(issue_inst_scheduled),
    .issue_destination_bitmap(issue_destination_bitmap)
  );

  typedef struct {
    thread_id_t           tid;
    instruction_decoded_t inst;
    scoreboard_t          dest;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input bit ok, input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic scoreboard_t sb(input int i);
    return scoreboard_t'(1) << i;
  endfunction

  function automatic instruction_decoded_t mk(input int op, input int d, input logic dv, input logic hd,
                                              input int s0, input logic s0v, input logic h0,
                                              input int s1, input logic s1v, input logic h1,
                                              input logic imm, input logic m);
    instruction_decoded_t r;
    r.op_code                  = 8'(op);
    r.destination              = reg_addr_t'(d);
    r.is_destination_vectorial = dv;
    r.has_destination          = hd;
    r.source0                  = reg_addr_t'(s0);
    r.is_source0_vectorial     = s0v;
    r.has_source0              = h0;
    r.source1                  = reg_addr_t'(s1);
    r.is_source1_vectorial     = s1v;
    r.has_source1              = h1;
    r.is_source1_immediate     = imm;
    r.mask_enable              = m;
    return r;
  endfunction

  // Monitor: one issue is expected exactly one edge after each predicted grant.
  initial begin
    exp_t e;
    logic en_s, rs_s;
    forever begin
      @(posedge clk);
      en_s = enable;
      rs_s = reset;
      #1;
      if (!rs_s) chk(issue_valid === 1'b0, "reset_issue_valid", issue_valid, 0);
      else if (en_s) begin
        if (issue_valid === 1'b1) begin
          if (q.size() == 0) chk(1'b0, "unexpected_issue", issue_thread_id, 0);
          else begin
            e = q.pop_front();
            chk(issue_thread_id === e.tid, "issue_thread_id", issue_thread_id, e.tid);
            chk(issue_inst_scheduled === e.inst, "issue_inst", issue_inst_scheduled, e.inst);
            chk(issue_destination_bitmap === e.dest, "issue_dest", issue_destination_bitmap, e.dest);
          end
        end else if (q.size() != 0) begin
          e = q.pop_front();
          chk(1'b0, "missing_issue", issue_valid, e.tid);
        end
      end
    end
  end

  // Called right after a falling edge with inputs set; checks the pop and predicts the issue.
  task automatic step(input logic [7:0] exp_deq, input scoreboard_t d, input string nm);
    exp_t e;
    #1;
    chk(ib_dequeue === exp_deq, nm, ib_dequeue, exp_deq);
    if (exp_deq != 0) begin
      for (int i = 0; i < THREAD_NUMB; i++)
        if (exp_deq[i]) begin
          e.tid  = thread_id_t'(i);
          e.inst = ib_inst[i];
        end
      e.dest = d;
      q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    ib_valid = '0; rollback_valid = '0; wb_valid = 1'b0; enable = 1'b1;
    reset = 1'b0;
    step(8'h00, '0, "reset_deq");
    reset = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    instruction_decoded_t held;
    reset = 1'b0; enable = 1'b1; ib_valid = '0; ib_inst = '0; thread_enable = '1;
    rollback_valid = '0; rollback_clear_bitmap = '0;
    wb_valid = 1'b0; wb_thread_id = '0; wb_register = '0; wb_is_scalar = 1'b0;
    repeat (2) @(negedge clk);
    chk(issue_valid === 1'b0, "rst_valid", issue_valid, 0);
    chk(issue_thread_id === '0, "rst_tid", issue_thread_id, 0);
    chk(issue_inst_scheduled === '0, "rst_inst", issue_inst_scheduled, 0);
    chk(issue_destination_bitmap === '0, "rst_dest", issue_destination_bitmap, 0);
    chk(ib_dequeue === '0, "rst_deq", ib_dequeue, 0);
    reset = 1'b1;

    // RAW on s5 blocks until writeback, then one more cycle.
    do_reset();
    ib_inst[0] = mk(1, 5,0,1, 1,0,1, 2,0,1, 0,0); ib_valid = 8'h01;
    step(8'h01, sb(5), "t1_add_s5");
    ib_inst[0] = mk(2, 6,0,1, 5,0,1, 3,0,1, 0,0);
    step(8'h00, '0, "t1_raw_block");
    step(8'h00, '0, "t1_raw_block2");
    wb_valid = 1'b1; wb_thread_id = 3'd0; wb_register = 6'd5; wb_is_scalar = 1'b1;
    step(8'h00, '0, "t1_wb_cycle");
    wb_valid = 1'b0;
    step(8'h01, sb(6), "t1_after_wb");
    ib_valid = '0;

    // Round robin 0,2,5 and wrap through 7.
    do_reset();
    ib_inst[0] = mk(3, 0,0,0, 1,0,1, 0,0,0, 0,0);
    ib_inst[2] = ib_inst[0]; ib_inst[5] = ib_inst[0];
    ib_inst[7] = ib_inst[0]; ib_inst[1] = ib_inst[0];
    ib_valid = 8'h25;
    step(8'h01, '0, "t2_rr0"); step(8'h04, '0, "t2_rr2"); step(8'h20, '0, "t2_rr5");
    step(8'h01, '0, "t2_rr0b"); step(8'h04, '0, "t2_rr2b"); step(8'h20, '0, "t2_rr5b");
    ib_valid = 8'h82;
    step(8'h80, '0, "t2_rr7"); step(8'h02, '0, "t2_wrap1");
    ib_valid = 8'h01; thread_enable = 8'hFE;
    step(8'h00, '0, "t2_thread_disabled");
    thread_enable = '1; ib_valid = '0;

    // WAW on v3; scalar s3 is a different bit.
    do_reset();
    ib_inst[1] = mk(4, 3,1,1, 0,0,0, 0,0,0, 0,0); ib_valid = 8'h02;
    step(8'h02, sb(REGISTER_NUMBER + 3), "t3_write_v3");
    step(8'h00, '0, "t3_waw_v3");
    step(8'h00, '0, "t3_waw_v3b");
    ib_inst[1] = mk(5, 3,0,1, 0,0,0, 0,0,0, 0,0);
    step(8'h02, sb(3), "t3_scalar_s3");
    ib_valid = '0;

    // Mask register busy; immediate source1 ignored; wb on another thread does not release.
    do_reset();
    ib_inst[4] = mk(6, 60,0,1, 1,0,1, 0,0,0, 0,0); ib_valid = 8'h10;
    step(8'h10, sb(60), "t4_write_s60");
    ib_inst[4] = mk(8, 0,0,0, 1,0,1, 60,0,1, 1,0);
    step(8'h10, '0, "t4_imm_src1");
    ib_inst[4] = mk(7, 2,1,1, 0,1,1, 1,1,1, 0,1);
    step(8'h00, '0, "t4_mask_busy");
    wb_valid = 1'b1; wb_thread_id = 3'd3; wb_register = 6'd60; wb_is_scalar = 1'b1;
    step(8'h00, '0, "t4_wb_other_thread");
    wb_thread_id = 3'd4;
    step(8'h00, '0, "t4_wb_cycle");
    wb_valid = 1'b0;
    step(8'h10, sb(REGISTER_NUMBER + 2), "t4_masked_issue");
    ib_valid = '0;

    // Freeze: outputs hold, release still lands, grant on first enabled cycle.
    do_reset();
    held = mk(9, 10,0,1, 0,0,0, 0,0,0, 0,0);
    ib_inst[3] = held; ib_valid = 8'h08;
    step(8'h08, sb(10), "t5_write_s10");
    ib_inst[3] = mk(10, 11,0,1, 10,0,1, 0,0,0, 0,0);
    enable = 1'b0;
    wb_valid = 1'b1; wb_thread_id = 3'd3; wb_register = 6'd10; wb_is_scalar = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(8'h00, '0, "t5_deq_frozen");
      wb_valid = 1'b0;
      chk(issue_valid === 1'b1, "t5_hold_valid", issue_valid, 1);
      chk(issue_thread_id === 3'd3, "t5_hold_tid", issue_thread_id, 3);
      chk(issue_inst_scheduled === held, "t5_hold_inst", issue_inst_scheduled, held);
      chk(issue_destination_bitmap === sb(10), "t5_hold_dest", issue_destination_bitmap, sb(10));
    end
    enable = 1'b1;
    step(8'h08, sb(11), "t5_grant_on_enable");
    ib_valid = '0;

    // Rollback releases s7/v1 and masks thread 2 in its cycle.
    do_reset();
    ib_inst[2] = mk(11, 7,0,1, 0,0,0, 0,0,0, 0,0); ib_valid = 8'h04;
    step(8'h04, sb(7), "t6_write_s7");
    ib_inst[2] = mk(12, 1,1,1, 0,0,0, 0,0,0, 0,0);
    step(8'h04, sb(REGISTER_NUMBER + 1), "t6_write_v1");
    ib_inst[2] = mk(13, 0,0,0, 7,0,1, 1,1,1, 0,0);
    ib_inst[6] = mk(14, 0,0,0, 1,0,1, 0,0,0, 0,0);
    ib_valid = 8'h44; rollback_valid = 8'h04;
    rollback_clear_bitmap = sb(7) | sb(REGISTER_NUMBER + 1);
    step(8'h40, '0, "t6_rollback_other");
    rollback_valid = '0; ib_valid = 8'h04;
    step(8'h04, '0, "t6_cleared");
    rollback_valid = 8'h04; rollback_clear_bitmap = '0;
    step(8'h00, '0, "t6_rollback_blocks");
    rollback_valid = '0; ib_valid = '0;

    // Reset mid-stream drops the pending pick and empties the scoreboard.
    ib_inst[0] = mk(15, 9,0,1, 0,0,0, 0,0,0, 0,0); ib_valid = 8'h01;
    step(8'h01, sb(9), "t7_write_s9");
    ib_inst[0] = mk(16, 0,0,0, 9,0,1, 0,0,0, 0,0);
    ib_inst[1] = mk(17, 20,0,1, 0,0,0, 0,0,0, 0,0);
    ib_valid = 8'h03; reset = 1'b0;
    step(8'h00, '0, "t7_reset_deq");
    chk(issue_thread_id === '0, "t7_rst_tid", issue_thread_id, 0);
    chk(issue_inst_scheduled === '0, "t7_rst_inst", issue_inst_scheduled, 0);
    chk(issue_destination_bitmap === '0, "t7_rst_dest", issue_destination_bitmap, 0);
    reset = 1'b1; ib_valid = 8'h01;
    step(8'h01, '0, "t7_sb_cleared");
    ib_valid = '0;

    repeat (3) step(8'h00, '0, "idle_deq");
    chk(q.size() == 0, "queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/issue_scheduler.md
Name: issue_scheduler

Overview:
- Issue stage sitting directly upstream of operand fetch.
- Takes one decoded instruction per thread from the per-thread instruction buffers and checks it for RAW/WAW hazards against a per-thread register scoreboard.
- Picks one eligible thread per cycle with a round-robin arbiter and drives the issue_* interface consumed by operand fetch.
- Scoreboard bits are set on issue and cleared by writeback release or rollback.

Parameters:
- THREAD_NUMB, 8, number of hardware threads (from `THREAD_NUMB).
- REGISTER_NUMBER, 64, registers per file (from `REGISTER_NUMBER).
- MASK_REG, 60, scalar register holding the lane mask (from `MASK_REG).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- enable  in  1  downstream advance; when 0 the stage freezes.
- ib_valid  in  THREAD_NUMB  per-thread instruction available at buffer head.
- ib_inst  in  THREAD_NUMB x instruction_decoded_t  per-thread buffer-head instruction.
- ib_dequeue  out  THREAD_NUMB  one-hot pop, combinational, asserted in the grant cycle.
- thread_enable  in  THREAD_NUMB  threads allowed to issue.
- rollback_valid  in  THREAD_NUMB  per-thread flush.
- rollback_clear_bitmap  in  scoreboard_t  bits to release for every thread with rollback_valid set.
- wb_valid  in  1  writeback release valid.
- wb_thread_id  in  thread_id_t  releasing thread.
- wb_register  in  reg_addr_t  released register.
- wb_is_scalar  in  1  released register is scalar.
- issue_valid  out  1  registered.
- issue_thread_id  out  thread_id_t  registered.
- issue_inst_scheduled  out  instruction_decoded_t  registered.
- issue_destination_bitmap  out  scoreboard_t  registered, one-hot destination bit or 0.

Behaviour:
- Scoreboard encoding, scoreboard_t = 2*REGISTER_NUMBER bits:
  - scalar register r maps to bit r;
  - vector register r maps to bit REGISTER_NUMBER+r.
- Per-thread request bitmap is the OR of:
  - source0, if used;
  - source1, if used and not immediate;
  - MASK_REG scalar bit, if mask_enable;
  - destination bit, if has_destination (WAW check).
- Hazard: (request & scoreboard[t]) != 0. The check uses the registered scoreboard only; there is no bypass of same-cycle releases, so a release makes the thread eligible one cycle later.
- Eligibility: eligible[t] = ib_valid[t] & thread_enable[t] & ~rollback_valid[t] & ~hazard[t] & enable & reset.
- Arbiter: round-robin, searching upward starting at rr_ptr and wrapping modulo THREAD_NUMB.
  - On a grant, rr_ptr <= granted+1, wrapping THREAD_NUMB-1 to 0.
  - With no grant, rr_ptr holds.
- Grant cycle:
  - ib_dequeue[g]=1;
  - scoreboard[g] |= destination bit;
  - next edge: issue_valid=1, issue_thread_id=g, issue_inst_scheduled=ib_inst[g], issue_destination_bitmap=destination bit.
- Latency: one cycle from grant to issue_valid.
- enable=1 with no grant: issue_valid <= 0 on the next edge.
- enable=0:
  - no grant, no dequeue, no scoreboard set;
  - all issue_* outputs hold their values;
  - releases (wb and rollback) still apply.
- Release:
  - wb_valid clears bit {wb_is_scalar ? wb_register : REGISTER_NUMBER+wb_register} of scoreboard[wb_thread_id];
  - each thread with rollback_valid set clears rollback_clear_bitmap.
- Simultaneous set and clear of the same bit on the same thread: set wins (this arises only through a protocol error, since the WAW check blocks it).
- rollback_valid[t] in the same cycle t would win: t is not granted; the arbiter chooses among the remaining threads in the same cycle.
- Reset (reset==0):
  - issue_valid=0, rr_ptr=0, all scoreboards=0, ib_dequeue=0;
  - issue_thread_id=0, issue_inst_scheduled=0, issue_destination_bitmap=0.
  - A mid-operation reset discards any pending issue and takes effect at the next edge.

Decomposition:
- Shared package (npu_defines): scoreboard_t, thread_id_t, reg_addr_t, instruction_decoded_t (fields source0/1, destination, is_source*_vectorial, is_destination_vectorial, is_source1_immediate, has_source0/1, has_destination, mask_enable), and a function reg_to_scoreboard_bit().
- Sub-module: rr_arbiter (parameter N; inputs request and update_en; outputs one-hot grant; holds its pointer internally).

Test Plan:
- Thread 0 issues `add s5,s1,s2`, then `add s6,s5,s3`. Required: second instruction blocked. After wb_valid for thread 0, s5 scalar: second instruction granted the following cycle, issue_valid one cycle after that, destination bitmap bit 6.
- Threads 0, 2 and 5 continuously valid with no hazards. Required: grants in order 0, 2, 5, 0, 2, 5; rr_ptr wraps correctly.
- Vector dest v3 outstanding on thread 1; a new vector write to v3. Required: blocked by WAW on bit REGISTER_NUMBER+3. A scalar write to s3 on thread 1 is not blocked.
- A masked vector op while MASK_REG is busy on thread 4. Required: stalls until the s60 release.
- enable=0 for 3 cycles with a grant pending. Required: issue_* outputs hold, ib_dequeue=0. A wb release during those cycles clears its bit, and the instruction is granted on the first enable=1 cycle.
- rollback_valid[2] with clear bitmap {s7, v1}. Required: thread 2 not granted that cycle, bits s7 and v1 cleared. Reset driven low mid-stream: issue_valid=0 and all scoreboards zero after the edge.
